// File: rtl/shift_issue.sv
// Issue stage ahead of the shift ALU: buffers shift instructions in a small FIFO,
// strobes the ALU one instruction per cycle and returns its result with a sequence tag.
`ifndef REGISTER_WIDTH
`define REGISTER_WIDTH 32
`endif

module shift_issue #(
    parameter int REG_WD = `REGISTER_WIDTH,
    parameter int DEPTH  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_instr,
    input  logic [REG_WD-1:0]          in_operand,
    output logic                       alu_enable,
    output logic [REG_WD-1:0]          alu_in,
    output logic [4:0]                 alu_shift,
    output logic [2:0]                 alu_op,
    input  logic [REG_WD-1:0]          aluout,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [REG_WD-1:0]          res_data,
    output logic [3:0]                 res_tag,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_C   = PW'(1);

    logic [7:0]        instr_mem_r [DEPTH];
    logic [REG_WD-1:0] oper_mem_r  [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     count_r;
    logic [3:0]        iss_seq_r;
    logic [3:0]        res_tag_r;
    logic              res_valid_r;
    logic [7:0]        err_count_r;

    logic full_s;
    logic empty_s;
    logic accept_s;
    logic legal_s;
    logic push_s;
    logic drop_s;
    logic issue_s;

    assign full_s   = (count_r == DEPTH_C);
    assign empty_s  = (count_r == {PW{1'b0}});
    assign accept_s = in_valid && !full_s;
    // Opcodes 6 and 7 are reserved: handshaken so upstream never stalls, but discarded.
    assign legal_s  = (in_instr[7:5] <= 3'd5);
    assign push_s   = accept_s && legal_s;
    assign drop_s   = accept_s && !legal_s;
    assign issue_s  = !empty_s && (!res_valid_r || res_ready);

    assign in_ready   = !full_s;
    assign alu_enable = issue_s;
    assign alu_in     = oper_mem_r[rd_ptr_r[AW-1:0]];
    assign alu_shift  = instr_mem_r[rd_ptr_r[AW-1:0]][4:0];
    assign alu_op     = instr_mem_r[rd_ptr_r[AW-1:0]][7:5];
    assign res_valid  = res_valid_r;
    assign res_data   = aluout;
    assign res_tag    = res_tag_r;
    assign count      = count_r;
    assign err_count  = err_count_r;

    // FIFO storage: write the tail on every legal accept.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_r[i] <= 8'd0;
                oper_mem_r[i]  <= {REG_WD{1'b0}};
            end
        end else if (push_s) begin
            instr_mem_r[wr_ptr_r[AW-1:0]] <= in_instr;
            oper_mem_r[wr_ptr_r[AW-1:0]]  <= in_operand;
        end else begin
            instr_mem_r <= instr_mem_r;
            oper_mem_r  <= oper_mem_r;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_C;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (issue_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_C;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, issue_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    // Result handshake and issue-sequence tagging.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            res_valid_r <= 1'b0;
            res_tag_r   <= 4'd0;
            iss_seq_r   <= 4'd0;
        end else if (issue_s) begin
            res_valid_r <= 1'b1;
            res_tag_r   <= iss_seq_r;
            iss_seq_r   <= iss_seq_r + 4'd1;
        end else if (res_ready) begin
            res_valid_r <= 1'b0;
            res_tag_r   <= res_tag_r;
            iss_seq_r   <= iss_seq_r;
        end else begin
            res_valid_r <= res_valid_r;
            res_tag_r   <= res_tag_r;
            iss_seq_r   <= iss_seq_r;
        end
    end

    // Saturating count of dropped reserved-opcode instructions.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_count_r <= 8'd0;
        end else if (drop_s && (err_count_r != 8'd255)) begin
            err_count_r <= err_count_r + 8'd1;
        end else begin
            err_count_r <= err_count_r;
        end
    end

endmodule

// File: tb/tb_shift_issue.sv
// Directed bench for shift_issue with a small registered shift-ALU model on the result path.
module tb_shift_issue;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_instr;
    logic [31:0] in_operand;
    logic        alu_enable;
    logic [31:0] alu_in;
    logic [4:0]  alu_shift;
    logic [2:0]  alu_op;
    logic [31:0] aluout;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_tag;
    logic [2:0]  count;
    logic [7:0]  err_count;

    int checks;
    int failures;

    shift_issue #(.REG_WD(32), .DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_operand(in_operand),
        .alu_enable(alu_enable), .alu_in(alu_in), .alu_shift(alu_shift), .alu_op(alu_op),
        .aluout(aluout),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
        .count(count), .err_count(err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [4:0] s, input logic [2:0] op);
        case (op)
            3'd0:    return a << s;
            3'd1:    return a >> s;
            3'd2:    return $signed(a) >>> s;
            default: return a;
        endcase
    endfunction

    // Shift ALU model: result registered on enable, held otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) aluout <= 32'd0;
        else if (alu_enable) aluout <= alu_fn(alu_in, alu_shift, alu_op);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0; in_valid = 1'b0; res_ready = 1'b1; in_instr = 8'd0; in_operand = 32'd0;
        repeat (2) step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; res_ready = 1'b1; in_instr = 8'd0; in_operand = 32'd0;
        repeat (2) step();
        @(negedge clock);
        checks++; if (count !== 3'd0 || in_ready !== 1'b1 || res_valid !== 1'b0 || res_tag !== 4'd0 || err_count !== 8'd0) begin
            failures++; $display("FAIL reset_values count=%0d in_ready=%b res_valid=%b res_tag=%0d err=%0d exp 0/1/0/0/0",
                                 count, in_ready, res_valid, res_tag, err_count);
        end
        step();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            checks++; if (alu_enable !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++; $display("FAIL idle_cycle%0d alu_enable=%b res_valid=%b in_ready=%b exp 0/0/1", c, alu_enable, res_valid, in_ready);
            end
            step();
        end
    endtask

    task automatic test_single_op();
        apply_reset();
        in_valid = 1'b1; in_instr = 8'b000_00100; in_operand = 32'h0000_00F0;
        @(negedge clock);
        checks++; if (in_ready !== 1'b1 || alu_enable !== 1'b0) begin
            failures++; $display("FAIL single_c0 in_ready=%b alu_enable=%b exp 1/0", in_ready, alu_enable);
        end
        step();
        in_valid = 1'b0;
        @(negedge clock);
        checks++; if (alu_enable !== 1'b1 || alu_op !== 3'd0 || alu_shift !== 5'd4 || alu_in !== 32'h0000_00F0) begin
            failures++; $display("FAIL single_c1 en=%b op=%0d sh=%0d in=%h exp 1/0/4/f0", alu_enable, alu_op, alu_shift, alu_in);
        end
        step();
        @(negedge clock);
        checks++; if (res_valid !== 1'b1 || res_tag !== 4'd0 || res_data !== 32'h0000_0F00) begin
            failures++; $display("FAIL single_c2 valid=%b tag=%0d data=%h exp 1/0/00000f00", res_valid, res_tag, res_data);
        end
        step();
        @(negedge clock);
        checks++; if (res_valid !== 1'b0) begin
            failures++; $display("FAIL single_c3 res_valid=%b exp 0", res_valid);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] exp_v;
        apply_reset();
        for (int c = 0; c < 22; c++) begin
            if (c < 20) begin
                in_valid = 1'b1; in_instr = {3'd0, 5'(c % 8)}; in_operand = 32'h0000_0100 + 32'(c);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clock);
            checks++; if (count > 3'd1) begin
                failures++; $display("FAIL stream_count c=%0d count=%0d exp <=1", c, count);
            end
            if (c >= 1 && c <= 20) begin
                checks++; if (alu_enable !== 1'b1 || alu_in !== 32'h0000_0100 + 32'(c - 1)) begin
                    failures++; $display("FAIL stream_issue c=%0d en=%b in=%h exp 1/%h", c, alu_enable, alu_in, 32'h0000_0100 + 32'(c - 1));
                end
            end
            if (c >= 2) begin
                exp_v = (32'h0000_0100 + 32'(c - 2)) << ((c - 2) % 8);
                checks++; if (res_valid !== 1'b1 || res_tag !== 4'((c - 2) % 16) || res_data !== exp_v) begin
                    failures++; $display("FAIL stream_result c=%0d valid=%b tag=%0d data=%h exp 1/%0d/%h",
                                         c, res_valid, res_tag, res_data, (c - 2) % 16, exp_v);
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_instr = {3'd1, 5'd1}; in_operand = 32'h0000_1000 << k;
            @(negedge clock);
            checks++; if (in_ready !== 1'b1) begin
                failures++; $display("FAIL bp_fill_ready k=%0d in_ready=%b exp 1", k, in_ready);
            end
            checks++; if (alu_enable !== (k == 1)) begin
                failures++; $display("FAIL bp_fill_enable k=%0d alu_enable=%b exp %0d", k, alu_enable, k == 1);
            end
            step();
        end
        in_operand = 32'h0000_1000 << 5;
        for (int k = 5; k < 8; k++) begin
            @(negedge clock);
            checks++; if (in_ready !== 1'b0 || count !== 3'd4 || alu_enable !== 1'b0) begin
                failures++; $display("FAIL bp_full k=%0d in_ready=%b count=%0d en=%b exp 0/4/0", k, in_ready, count, alu_enable);
            end
            checks++; if (res_valid !== 1'b1 || res_data !== 32'h0000_0800 || res_tag !== 4'd0) begin
                failures++; $display("FAIL bp_hold k=%0d valid=%b data=%h tag=%0d exp 1/00000800/0", k, res_valid, res_data, res_tag);
            end
            step();
        end
        res_ready = 1'b1;
        @(negedge clock);
        checks++; if (in_ready !== 1'b0 || count !== 3'd4 || alu_enable !== 1'b1 || alu_in !== 32'h0000_2000) begin
            failures++; $display("FAIL bp_release in_ready=%b count=%0d en=%b in=%h exp 0/4/1/00002000", in_ready, count, alu_enable, alu_in);
        end
        step();
        @(negedge clock);
        checks++; if (in_ready !== 1'b1 || res_tag !== 4'd1 || res_data !== 32'h0000_1000 || alu_in !== 32'h0000_4000) begin
            failures++; $display("FAIL bp_drain9 in_ready=%b tag=%0d data=%h in=%h exp 1/1/00001000/00004000", in_ready, res_tag, res_data, alu_in);
        end
        step();
        in_valid = 1'b0;
        for (int j = 10; j < 14; j++) begin
            @(negedge clock);
            checks++; if (res_valid !== 1'b1 || res_tag !== 4'(j - 8) || res_data !== (32'h0000_0800 << (j - 8))) begin
                failures++; $display("FAIL bp_drain%0d valid=%b tag=%0d data=%h exp 1/%0d/%h", j, res_valid, res_tag, res_data, j - 8, 32'h0000_0800 << (j - 8));
            end
            checks++; if (alu_enable !== (j <= 12) || count !== 3'(13 - j)) begin
                failures++; $display("FAIL bp_occ%0d en=%b count=%0d exp %0d/%0d", j, alu_enable, count, j <= 12, 13 - j);
            end
            step();
        end
    endtask

    task automatic test_reserved();
        apply_reset();
        for (int k = 6; k < 8; k++) begin
            in_valid = 1'b1; in_instr = {3'(k), 5'd2}; in_operand = 32'h0000_0077;
            @(negedge clock);
            checks++; if (in_ready !== 1'b1) begin
                failures++; $display("FAIL rsv_ready op=%0d in_ready=%b exp 1", k, in_ready);
            end
            step();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            checks++; if (err_count !== 8'd2 || count !== 3'd0 || alu_enable !== 1'b0 || res_valid !== 1'b0) begin
                failures++; $display("FAIL rsv_drop err=%0d count=%0d en=%b valid=%b exp 2/0/0/0", err_count, count, alu_enable, res_valid);
            end
            step();
        end
        for (int c = 0; c < 300; c++) begin
            in_valid = 1'b1; in_instr = {((c % 2) == 0) ? 3'd6 : 3'd7, 5'd0};
            step();
        end
        in_valid = 1'b0;
        @(negedge clock);
        checks++; if (err_count !== 8'd255 || count !== 3'd0) begin
            failures++; $display("FAIL rsv_saturate err=%0d count=%0d exp 255/0", err_count, count);
        end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        res_ready = 1'b0;
        in_valid = 1'b1; in_instr = {3'd7, 5'd0}; in_operand = 32'd0;
        step();
        for (int k = 0; k < 4; k++) begin
            in_instr = {3'd0, 5'd0}; in_operand = 32'h0000_0010 + 32'(k);
            step();
        end
        in_valid = 1'b0;
        @(negedge clock);
        checks++; if (count !== 3'd3 || res_valid !== 1'b1 || err_count !== 8'd1) begin
            failures++; $display("FAIL mid_pre count=%0d valid=%b err=%0d exp 3/1/1", count, res_valid, err_count);
        end
        #2 reset = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || res_valid !== 1'b0 || err_count !== 8'd0 || alu_enable !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL mid_async count=%0d valid=%b err=%0d en=%b rdy=%b exp 0/0/0/0/1", count, res_valid, err_count, alu_enable, in_ready);
        end
        step();
        reset = 1'b1; res_ready = 1'b1;
        in_valid = 1'b1; in_instr = {3'd0, 5'd3}; in_operand = 32'h0000_0005;
        @(negedge clock);
        checks++; if (in_ready !== 1'b1) begin
            failures++; $display("FAIL mid_accept in_ready=%b exp 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        @(negedge clock);
        checks++; if (alu_enable !== 1'b1 || alu_in !== 32'h0000_0005) begin
            failures++; $display("FAIL mid_issue en=%b in=%h exp 1/00000005", alu_enable, alu_in);
        end
        step();
        @(negedge clock);
        checks++; if (res_valid !== 1'b1 || res_tag !== 4'd0 || res_data !== 32'h0000_0028) begin
            failures++; $display("FAIL mid_result valid=%b tag=%0d data=%h exp 1/0/00000028", res_valid, res_tag, res_data);
        end
        step();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single_op();
        test_streaming();
        test_backpressure();
        test_reserved();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
